// File: rtl/time_display_if.sv
// time_display_if: seconds input, BCD time and 7-segment display signals of the time display driver
interface time_display_if #(
  parameter int SECS_W = 17
);
  logic [SECS_W-1:0] secs;
  logic [7:0]        an;
  logic [6:0]        seg;
  logic              dp;
  logic [7:0]        hours_bcd;
  logic [7:0]        mins_bcd;
  logic [7:0]        secs_bcd;
  logic              busy;
  modport master (
    input  secs,
    output an, seg, dp, hours_bcd, mins_bcd, secs_bcd, busy
  );
  modport slave (
    output secs,
    input  an, seg, dp, hours_bcd, mins_bcd, secs_bcd, busy
  );
endinterface

// File: rtl/time_display_driver.sv
// time_display_driver: seconds-of-day to HH:MM:SS BCD converter driving an 8-digit multiplexed 7-segment display
// Optional blinking separator on digits 2 and 5: define TIME_DISP_DP_BLINK_EN.
module time_display_driver #(
  parameter int CLK_HZ  = 100000000,
  parameter int SCAN_HZ = 1000,
  parameter int SECS_W  = 17
) (
  input logic            clk,
  input logic            reset,
  time_display_if.master bus
);
  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int PW = DWELL > 2 ? $clog2(DWELL) : 1;
  localparam logic [SECS_W-1:0] DAY  = SECS_W'(86400);
  localparam logic [SECS_W-1:0] HOUR = SECS_W'(3600);
  localparam logic [SECS_W-1:0] MIN  = SECS_W'(60);
  localparam logic [SECS_W-1:0] TEN  = SECS_W'(10);
  typedef enum logic [2:0] {IDLE, WRAP, HRS, MINS, SECS, COMMIT} state_t;
  state_t state, state_n;
  logic [SECS_W-1:0] work, last_secs;
  logic [3:0] h_t, h_u, m_t, m_u, s_t, s_u;
  logic [PW-1:0] presc;
  logic [2:0] idx;
  logic [3:0] nib;
  logic [6:0] seg_n;
  // conversion state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // next state: each subtract state loops while its divisor still fits
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.secs != last_secs ? WRAP : IDLE;
      WRAP:    state_n = HRS;
      HRS:     state_n = work >= HOUR ? HRS : MINS;
      MINS:    state_n = work >= MIN ? MINS : SECS;
      SECS:    state_n = work >= TEN ? SECS : COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // conversion datapath; accumulators stay private until the commit cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      work          <= '0;
      last_secs     <= '0;
      {h_t, h_u, m_t, m_u, s_t, s_u} <= '0;
      bus.hours_bcd <= '0;
      bus.mins_bcd  <= '0;
      bus.secs_bcd  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.secs != last_secs) begin
          work      <= bus.secs;
          last_secs <= bus.secs;
          {h_t, h_u, m_t, m_u, s_t, s_u} <= '0;
          bus.busy  <= 1'b1;
        end
        WRAP: if (work >= DAY) work <= work - DAY;
        HRS: if (work >= HOUR) begin
          work <= work - HOUR;
          h_u  <= h_u == 4'd9 ? 4'd0 : h_u + 4'd1;
          h_t  <= h_u == 4'd9 ? h_t + 4'd1 : h_t;
        end
        MINS: if (work >= MIN) begin
          work <= work - MIN;
          m_u  <= m_u == 4'd9 ? 4'd0 : m_u + 4'd1;
          m_t  <= m_u == 4'd9 ? m_t + 4'd1 : m_t;
        end
        SECS: if (work >= TEN) begin
          work <= work - TEN;
          s_t  <= s_t + 4'd1;
        end else s_u <= work[3:0];
        COMMIT: begin
          bus.hours_bcd <= {h_t, h_u};
          bus.mins_bcd  <= {m_t, m_u};
          bus.secs_bcd  <= {s_t, s_u};
          bus.busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end
  // scan prescaler and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(DWELL - 1)) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else presc <= presc + 1'b1;
  end
  // digit content for the current index; 4'hF decodes to blank
  always_comb begin
    nib = idx == 3'd0 ? bus.secs_bcd[3:0]  :
          idx == 3'd1 ? bus.secs_bcd[7:4]  :
          idx == 3'd3 ? bus.mins_bcd[3:0]  :
          idx == 3'd4 ? bus.mins_bcd[7:4]  :
          idx == 3'd6 ? bus.hours_bcd[3:0] :
          idx == 3'd7 ? bus.hours_bcd[7:4] : 4'hF;
  end
  // active-low segment decode {g,f,e,d,c,b,a}
  always_comb begin
    seg_n = 7'h7F;
    case (nib)
      4'd0: seg_n = 7'h40;
      4'd1: seg_n = 7'h79;
      4'd2: seg_n = 7'h24;
      4'd3: seg_n = 7'h30;
      4'd4: seg_n = 7'h19;
      4'd5: seg_n = 7'h12;
      4'd6: seg_n = 7'h02;
      4'd7: seg_n = 7'h78;
      4'd8: seg_n = 7'h00;
      4'd9: seg_n = 7'h10;
      default: seg_n = 7'h7F;
    endcase
  end
  // registered display pins, one cycle behind the digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.an  <= 8'hFF;
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= ~(8'b1 << idx);
      bus.seg <= seg_n;
`ifdef TIME_DISP_DP_BLINK_EN
      bus.dp  <= ~((idx == 3'd2 || idx == 3'd5) && !bus.secs_bcd[0]);
`else
      bus.dp  <= 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_time_display_driver.sv
// tb_time_display_driver: randomized conversion and scan checks against an arithmetic reference model
module tb_time_display_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_v = 0;
  logic [23:0] exp_bcd = '0;
  logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  time_display_if #(.SECS_W(17)) bus ();
  time_display_driver #(.CLK_HZ(32), .SCAN_HZ(8), .SECS_W(17)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [23:0] ref_bcd(input int s);
    int t, h, m, x;
    t = s % 86400;
    h = t / 3600;
    m = (t % 3600) / 60;
    x = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    return n > 4'd9 ? 7'h7F : codes[n];
  endfunction
  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, 32'(n), 32'd0);
  endtask
  task automatic convert(input int v, input string tag);
    int n;
    bit changed;
    changed = v != last_v;
    @(negedge clk);
    bus.secs = 17'(v);
    @(negedge clk);
    if (changed) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_idle(tag, n);
    if (changed) check({tag, "_lat"}, 32'(n + 1 <= 93), 32'd1);
    exp_bcd = ref_bcd(v);
    last_v = v;
    check({tag, "_bcd"}, {8'h0, bus.hours_bcd, bus.mins_bcd, bus.secs_bcd}, {8'h0, exp_bcd});
  endtask
  task automatic scan(input string tag);
    int k;
    logic [3:0] d [8];
    logic exp_dp;
    d = '{exp_bcd[3:0], exp_bcd[7:4], 4'hF, exp_bcd[11:8], exp_bcd[15:12], 4'hF, exp_bcd[19:16], exp_bcd[23:20]};
    repeat (2) @(negedge clk);
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      k = ((cyc - 1) / 4) % 8;
`ifdef TIME_DISP_DP_BLINK_EN
      exp_dp = (k == 2 || k == 5) ? exp_bcd[0] : 1'b1;
`else
      exp_dp = 1'b1;
`endif
      check({tag, "_an"}, 32'(bus.an), 32'(8'(~(8'b1 << k))));
      check({tag, "_seg"}, 32'(bus.seg), 32'(seg_of(d[k])));
      check({tag, "_dp"}, 32'(bus.dp), 32'(exp_dp));
    end
  endtask
  initial begin
    int n, b, v;
    bus.secs = '0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(bus.an), 32'hFF);
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_dp", 32'(bus.dp), 32'd1);
    check("rst_bcd", {8'h0, bus.hours_bcd, bus.mins_bcd, bus.secs_bcd}, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    b = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) b++;
    end
    check("idle_busy", 32'(b), 32'd0);
    convert(3661, "t3661");
    convert(86399, "t86399");
    convert(90000, "t90000");
    convert(131071, "tmax");
    @(negedge clk);
    bus.secs = 17'd100;
    repeat (2) @(negedge clk);
    bus.secs = 17'd200;
    wait_idle("first", n);
    check("first_bcd", {8'h0, bus.hours_bcd, bus.mins_bcd, bus.secs_bcd}, {8'h0, ref_bcd(100)});
    @(negedge clk);
    check("second_busy", 32'(bus.busy), 32'd1);
    wait_idle("second", n);
    exp_bcd = ref_bcd(200);
    last_v = 200;
    check("second_bcd", {8'h0, bus.hours_bcd, bus.mins_bcd, bus.secs_bcd}, {8'h0, exp_bcd});
    convert(45296, "t123456");
    scan("scan56");
    convert(45297, "t123457");
    scan("scan57");
    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 131071));
      if (v == last_v) v = (v + 1) % 131072;
      convert(v, "rand");
      if (i % 5 == 0) scan("rscan");
    end
    @(negedge clk);
    bus.secs = 17'd50000;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_bcd", {8'h0, bus.hours_bcd, bus.mins_bcd, bus.secs_bcd}, 32'd0);
    check("mid_rst_an", 32'(bus.an), 32'hFF);
    reset = 1'b0;
    last_v = 0;
    convert(50000, "post_rst");
    scan("post_scan");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/time_display_driver.md
Name: time_display_driver

Overview:
- Reads the 17-bit seconds-of-day count from the clock mechanism and converts it to HH:MM:SS BCD with a sequential subtract-based FSM.
- Time-multiplexes the result onto the board's 8-digit common-anode 7-segment display.
- Sits between the clock mechanism and the board display pins; it is the display-side consumer of the time count.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz. Per-digit dwell = CLK_HZ/SCAN_HZ cycles; must be >= 2.
- SECS_W, 17, width of the seconds input.

Ports:
- clk  in  1  system clock
- reset  in  1  reset
- secs  in  SECS_W  seconds-of-day count, sampled in clk domain
- an  out  8  anodes, active-low, one-hot-low while scanning
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- hours_bcd  out  8  {tens,units} BCD hours
- mins_bcd  out  8  {tens,units} BCD minutes
- secs_bcd  out  8  {tens,units} BCD seconds
- busy  out  1  high while a conversion is in progress

Behaviour:
- Clocking/reset: clock clk; reset reset, synchronous, active-high. All outputs are registered.
- Reset values: an=8'hFF, seg=7'h7F, dp=1, all BCD outputs=0, busy=0, last_secs=0, digit index=0, prescaler=0.
- FSM states: IDLE, WRAP, HRS, MINS, SECS, COMMIT.
- IDLE: when secs != last_secs, capture secs into work and last_secs, clear the BCD accumulators, set busy=1, go to WRAP. Otherwise stay.
- WRAP: if work >= 86400, subtract 86400 (one subtraction suffices for 17 bits). Go to HRS.
- HRS: if work >= 3600, subtract 3600 and BCD-increment the hour accumulator (units 9 -> 0 with tens+1), stay. Otherwise go to MINS.
- MINS: same scheme with 60 and the minute accumulator. Otherwise go to SECS.
- SECS: if work >= 10, subtract 10 and increment the seconds tens digit, stay. Otherwise seconds units = work[3:0], go to COMMIT.
- COMMIT: copy accumulators to hours_bcd/mins_bcd/secs_bcd in one cycle, busy=0, go to IDLE.
- BCD outputs change only in COMMIT. No partial values are ever visible.
- Latency from the first differing secs sample to updated outputs: <= 92 cycles (worst case 86399).
- secs changes while busy are ignored. The IDLE compare picks up the latest value on the next pass. No value is queued.
- Reset mid-conversion aborts to IDLE with reset values.
- Scan prescaler: counts 0..CLK_HZ/SCAN_HZ-1. At terminal count, digit index increments 0->7, then wraps 7->0.
- Digit map (index: content):
  - 0: secs units
  - 1: secs tens
  - 2: blank
  - 3: mins units
  - 4: mins tens
  - 5: blank
  - 6: hours units
  - 7: hours tens
- an[i]=0 only for the current index. Outputs are registered one cycle after the index; the first cycle after reset release drives index 0.
- Blank digit: seg=7'h7F.
- Segment codes, digits 0-9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex). Nibbles > 9 display blank.
- dp=1 at all times unless the optional feature is enabled.

Optional Feature:
- Macro: TIME_DISP_DP_BLINK_EN.
- Defined: dp=0 on digits 2 and 5 when the committed secs_bcd units value is even, dp=1 when odd. This gives a separator that blinks at 0.5 Hz. All other digits keep dp=1.
- Undefined: dp is a constant 1 and no parity logic is present.

Test Plan:
- Reset held 3 cycles, secs=0 -> an=FF, seg=7F, dp=1, BCD outputs 00/00/00, busy=0. After release, busy never rises.
- secs=3661 -> busy rises within 1 cycle; within 92 cycles hours_bcd=8'h01, mins_bcd=8'h01, secs_bcd=8'h01, busy=0.
- secs=86399 -> 8'h23/8'h59/8'h59. Then secs=90000 -> wrap to 8'h01/8'h00/8'h00.
- secs 100 then 200 two cycles later (mid-conversion) -> first 00/01/40 committed, then 00/03/20; busy deasserts twice.
- CLK_HZ=32, SCAN_HZ=8, committed 12:34:56 -> an steps FE, FD, FB, F7, EF, DF, BF, 7F every 4 cycles, then wraps to FE. seg sequence 02, 12, 7F, 19, 30, 7F, 24, 79.
- TIME_DISP_DP_BLINK_EN defined, secs_bcd units=6 -> dp=0 only when an=FB or DF. With units=7 -> dp=1 always. Macro undefined -> dp=1 always.
